// File: rtl/morse_transmissor.sv
// Serializes a 5-symbol Morse code (bit 4 first, 1=dot, 0=dash) into timed key on/off.
// Define MORSE_CHAR_GAP_EN to append the 3-unit inter-character gap before returning idle.
module morse_transmissor #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] code,
  input  logic       valid,
  output logic       ready,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(3*UNIT_CYCLES+1);
  // Timer holds (duration-1) and the state advances on the cycle it reads zero.
  localparam logic [TW-1:0] T_UNIT = TW'(UNIT_CYCLES-1);
  localparam logic [TW-1:0] T_DASH = TW'(3*UNIT_CYCLES-1);
`ifdef MORSE_CHAR_GAP_EN
  // One cycle short: the idle/ready cycle supplies the final gap cycle,
  // so back-to-back characters see exactly 3 units of key low.
  localparam logic [TW-1:0] T_GAP  = TW'(3*UNIT_CYCLES-2);
`endif

  typedef enum logic [1:0] {IDLE, MARK, SPACE, CHAR_GAP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [4:0]      sreg;
  logic [2:0]      idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      sreg  <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            sreg  <= code;
            idx   <= '0;
            timer <= code[4] ? T_UNIT : T_DASH;
            state <= MARK;
          end
        end
        MARK: begin
          if (timer == '0) begin
            if (idx < 3'd4) begin
              timer <= T_UNIT;
              state <= SPACE;
            end else begin
`ifdef MORSE_CHAR_GAP_EN
              timer <= T_GAP;
              state <= CHAR_GAP;
`else
              done  <= 1'b1;
              state <= IDLE;
`endif
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SPACE: begin
          if (timer == '0) begin
            idx   <= idx + 3'd1;
            sreg  <= {sreg[3:0], 1'b0};
            timer <= sreg[3] ? T_UNIT : T_DASH;
            state <= MARK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
`ifdef MORSE_CHAR_GAP_EN
          if (timer == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign key   = (state == MARK);
  assign busy  = ~ready;

endmodule
